// File: rtl/mul_div_unit.sv
// Multiply/divide unit with HI/LO registers and a counted busy window.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (codes 9-12).
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        req,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] md_out,
    output logic        state_dbg
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] hi, lo, hi_p, lo_p;

    logic        is_mul, is_div, mul_signed, div_signed, multi;
`ifdef MDU_MADD_EN
    logic        is_acc, acc_sub;
`endif

    always_comb begin
        is_mul     = (md_op == OP_MULT) || (md_op == OP_MULTU);
        is_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);
        div_signed = (md_op == OP_DIV);
        mul_signed = (md_op == OP_MULT);
`ifdef MDU_MADD_EN
        is_acc     = (md_op == OP_MADD) || (md_op == OP_MADDU) ||
                     (md_op == OP_MSUB) || (md_op == OP_MSUBU);
        acc_sub    = (md_op == OP_MSUB) || (md_op == OP_MSUBU);
        mul_signed = mul_signed || (md_op == OP_MADD) || (md_op == OP_MSUB);
        multi      = is_mul || is_div || is_acc;
`else
        multi      = is_mul || is_div;
`endif
    end

    // Handshake: start is a one-cycle accept of a multi-cycle op; while busy is high
    // no new HI/LO-class op may be presented, and the hazard unit stalls ID on start|busy.
    assign start     = multi && !req && !busy;
    assign state_dbg = state;

    logic [63:0] prod_s, prod_u, prod;
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod   = mul_signed ? prod_s : prod_u;

    // Signed division via magnitudes: quotient truncates toward zero, remainder follows dividend.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, q_u, r_u, q_res, r_res;
    always_comb begin
        a_neg = div_signed && A[31];
        b_neg = div_signed && B[31];
        a_mag = a_neg ? -A : A;
        b_mag = b_neg ? -B : B;
        q_u   = (b_mag != 32'd0) ? (a_mag / b_mag) : 32'd0;
        r_u   = (b_mag != 32'd0) ? (a_mag % b_mag) : 32'd0;
        q_res = (a_neg ^ b_neg) ? -q_u : q_u;
        r_res = a_neg ? -r_u : r_u;
    end

    logic [31:0] res_hi, res_lo;
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        if (is_mul) begin
            {res_hi, res_lo} = prod;
        end else if (is_div && (B != 32'd0)) begin
            res_hi = r_res;
            res_lo = q_res;
        end
`ifdef MDU_MADD_EN
        else if (is_acc) begin
            {res_hi, res_lo} = acc_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            hi_p  <= 32'd0;
            lo_p  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hi_p  <= res_hi;
                        lo_p  <= res_lo;
                        cnt   <= is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (!req && md_op == OP_MTHI) begin
                        hi <= A;
                    end else if (!req && md_op == OP_MTLO) begin
                        lo <= A;
                    end
                end
                RUN: begin
                    if (cnt == 5'd1) begin
                        hi    <= hi_p;
                        lo    <= lo_p;
                        cnt   <= 5'd0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        md_out = 32'd0;
        if (md_op == OP_MFHI)      md_out = hi;
        else if (md_op == OP_MFLO) md_out = lo;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed plus randomized bench for mul_div_unit against an arithmetic HI/LO model.
module tb_mul_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        req;
  logic [31:0] A, B;
  logic        start, busy, state_dbg;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .req(req), .A(A), .B(B),
    .start(start), .busy(busy), .md_out(md_out), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  // Architectural effect of one accepted op on the HI/LO model.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p, acc;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    case (op)
      4'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd2: begin p = ua * ub; hi_m = p[63:32]; lo_m = p[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
      4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
      4'd5: hi_m = a;
      4'd6: lo_m = a;
`ifdef MDU_MADD_EN
      4'd9, 4'd10, 4'd11, 4'd12: begin
        if (op == 4'd9 || op == 4'd11) p = sa * sb;
        else p = ua * ub;
        acc = {hi_m, lo_m};
        acc = (op >= 4'd11) ? acc - p : acc + p;
        hi_m = acc[63:32];
        lo_m = acc[31:0];
      end
`endif
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic r, input string tag);
    bit multi;
    int n;
    int exp_n;
    multi = is_multi(op);
    @(negedge clk);
    check_val({31'd0, busy}, 32'd0, {tag, "_issue_idle"});
    md_op = op; A = a; B = b; req = r;
    #1;
    check_val({31'd0, start}, {31'd0, multi && !r}, {tag, "_start"});
    @(negedge clk);
    md_op = 4'd0; req = 1'b0; A = 32'd0; B = 32'd0;
    if (multi && !r) begin
      exp_n = (op == 4'd3 || op == 4'd4) ? DC : MC;
      n = 0;
      while (busy && n < 40) begin
        n++;
        @(negedge clk);
      end
      check_val(32'(n), 32'(exp_n), {tag, "_busy_len"});
      model_exec(op, a, b);
    end else begin
      check_val({31'd0, busy}, 32'd0, {tag, "_no_busy"});
      if (!r) model_exec(op, a, b);
    end
  endtask

  task automatic read_hilo(input string tag);
    @(negedge clk);
    md_op = 4'd7;
    #1 check_val(md_out, hi_m, {tag, "_hi"});
    md_op = 4'd8;
    #1 check_val(md_out, lo_m, {tag, "_lo"});
    md_op = 4'd0;
    #1 check_val(md_out, 32'd0, {tag, "_none_out"});
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] ra, rb;
    logic        rr;

    reset = 1'b1; md_op = 4'd0; req = 1'b0; A = 32'd0; B = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_val({31'd0, busy}, 32'd0, "reset_busy");
    check_val({31'd0, start}, 32'd0, "reset_start");
    read_hilo("reset");

    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, "mult_signed");
    read_hilo("mult_signed");

    do_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_signed");
    read_hilo("div_signed");
    do_op(4'd4, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");
    read_hilo("divu_zero");

    do_op(4'd1, 32'd7, 32'd9, 1'b1, "mult_flush");
    repeat (3) @(negedge clk);
    check_val({31'd0, busy}, 32'd0, "mult_flush_later");
    read_hilo("mult_flush");
    do_op(4'd5, 32'h0000_1234, 32'd0, 1'b1, "mthi_flush");
    read_hilo("mthi_flush");

    do_op(4'd6, 32'hDEAD_BEEF, 32'd0, 1'b0, "mtlo");
    read_hilo("mtlo");

    do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
    read_hilo("div_ovf");
    do_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    read_hilo("multu_max");

    do_op(4'd5, 32'd0, 32'd0, 1'b0, "acc_mthi");
    do_op(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0, "acc_mtlo");
    do_op(4'd10, 32'd1, 32'd1, 1'b0, "maddu");
    read_hilo("maddu");
    do_op(4'd11, 32'hFFFF_FFFD, 32'd4, 1'b0, "msub");
    read_hilo("msub");

    // Reset landing in the third busy cycle of a multu.
    do_op(4'd5, 32'h0000_0005, 32'd0, 1'b0, "rst_pre");
    @(negedge clk);
    md_op = 4'd2; A = 32'd7; B = 32'd9; req = 1'b0;
    #1 check_val({31'd0, start}, 32'd1, "rst_start");
    @(negedge clk);
    md_op = 4'd0;
    check_val({31'd0, busy}, 32'd1, "rst_busy1");
    @(negedge clk);
    @(negedge clk);
    check_val({31'd0, busy}, 32'd1, "rst_busy3");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val({31'd0, busy}, 32'd0, "rst_busy_cleared");
    hi_m = 32'd0; lo_m = 32'd0;
    read_hilo("rst_after");
    repeat (12) @(negedge clk);
    check_val({31'd0, busy}, 32'd0, "rst_busy_later");
    read_hilo("rst_later");

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(1, 12));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
      rr = ($urandom_range(0, 7) == 0);
      do_op(op, ra, rb, rr, $sformatf("rand%0d_op%0d", i, op));
      read_hilo($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multiply/divide unit for the P7 five-stage MIPS pipeline, in the EX stage beside the ALU. It owns the HI/LO registers and sequences the multi-cycle operations mult, multu, div and divu. It exports `start` and `busy`, which the hazard unit uses to stall any HI/LO-class instruction waiting in ID. It also serves mfhi/mflo reads and mthi/mtlo writes.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (and madd-class ops); legal range 1–31.
- `DIV_CYCLES`, default 10: busy cycles for div/divu; legal range 1–31.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `md_op` input 4: EX-stage operation code:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo.
  - 9 madd, 10 maddu, 11 msub, 12 msubu (only when `MDU_MADD_EN` is defined).
  - All other codes are treated as none.
- `req` input 1: exception/interrupt flush of the EX instruction. When high, the EX op has no architectural effect.
- `A` input 32: rs operand, forwarded.
- `B` input 32: rt operand, forwarded.
- `start` output 1: combinational. High when `md_op` is a multi-cycle code, `req`=0 and `busy`=0.
- `busy` output 1: registered. High while a multi-cycle operation is in flight.
- `md_out` output 32: combinational. Returns HI for mfhi, LO for mflo, otherwise 0.

## Operation
- State machine has two states, IDLE and RUN. It holds a 5-bit down-counter `cnt` and 32-bit pending registers `hi_p` and `lo_p`.
- **IDLE, with `start`=1:**
  - Compute the result from A/B in this cycle and latch it into `hi_p`/`lo_p`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES; go to RUN.
- **RUN:**
  - `cnt` decrements each cycle.
  - On the cycle `cnt`==1: HI←`hi_p`, LO←`lo_p`, `busy` falls, return to IDLE.
- **mthi/mtlo in IDLE with `req`=0:** HI←A or LO←A at the clock edge, with no busy period.
- **Any op while `busy`=1:** ignored. The hazard unit guarantees this never occurs; the bench asserts on it.
- **Arithmetic:**
  - mult: signed 64-bit product. multu: unsigned 64-bit product. HI = product[63:32], LO = product[31:0].
  - div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed) gives LO=0x80000000, HI=0.
  - Divide by zero: busy runs the full DIV_CYCLES, and HI/LO keep their previous values.
- `req`=1 while busy does not abort the in-flight operation, because it belongs to an older, committed instruction.

## Timing
- **Reset:** HI=0, LO=0, `busy`=0, `cnt`=0, state IDLE, pending registers 0. A reset mid-RUN discards the pending result.
- **Busy window:** with `start` high in cycle T, `busy` is high in cycles T+1 … T+N (N = MULT_CYCLES or DIV_CYCLES). HI/LO hold the new value from cycle T+N+1.
- **Interaction with the hazard unit:** it stalls ID on `start|busy`. The earliest mfhi can reach EX is cycle T+N+1, and it then reads the new HI.
- **Simultaneous `start` and `req`:** `req` wins. No state change and `busy` stays 0. `start` itself reads 0 because of `req`.
- **`md_out`:** reflects the current HI/LO in the same cycle. No bypass from `hi_p`/`lo_p`.

## Configuration
- `MDU_MADD_EN` defined:
  - Codes 9–12 are multi-cycle ops with MULT_CYCLES latency.
  - Result = {HI,LO} ± product: signed for madd/msub, unsigned for maddu/msubu.
  - The accumulator {HI,LO} is sampled at start.
- `MDU_MADD_EN` not defined: codes 9–12 decode as none. `start`=0, no effect.

## Test plan
- **Signed mult:** A=0xFFFFFFFE, B=3, mult → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mfhi gives `md_out`=0xFFFFFFFF.
- **Signed div:** A=0xFFFFFFF9 (−7), B=2, div → `busy` high exactly 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with B=0 → HI/LO unchanged after 10 busy cycles.
- **Flush:** mult issued with `req`=1 → `start`=0, `busy` never rises, HI/LO unchanged. mthi A=0x1234 with `req`=1 → HI unchanged.
- **Move ops:** mtlo A=0xDEADBEEF → LO=0xDEADBEEF next cycle, no busy; mflo returns it.
- **Reset mid-operation:** reset in the 3rd busy cycle of multu → next cycle `busy`=0, HI=LO=0, no later write-back.
- **Accumulate (with `MDU_MADD_EN`):** HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 → after 5 busy cycles HI=1, LO=0. Without the macro, the same op → no change.
